// File: rtl/bit_index_serializer.sv
// Serializes the set-bit positions of an accepted word as ascending index beats.
// Optional BIT_INDEX_SERIALIZER_COUNT_EN adds count_o (population count of the accepted word).
module bit_index_serializer #(
    parameter int unsigned WIDTH = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     data_val_i,
    output logic                     data_ready_o,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     idx_val_o,
    output logic                     idx_last_o,
    output logic                     idx_empty_o,
`ifdef BIT_INDEX_SERIALIZER_COUNT_EN
    output logic [$clog2(WIDTH):0]   count_o,
`endif
    input  logic                     idx_ready_i
);

    localparam int unsigned IdxW = $clog2(WIDTH);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StEmit = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             empty_q, empty_d;

    logic [IdxW-1:0]  low_idx;
    logic [WIDTH-1:0] low_oh;
    logic             one_left;
    logic             accept;
    logic             beat_done;

    assign accept    = (state_q == StIdle) && data_val_i;
    assign beat_done = (state_q == StEmit) && idx_ready_i;

    // Lowest set bit of the remaining mask; an empty mask reports index 0.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx = IdxW'(i);
            end
        end
    end

    assign low_oh   = mask_q & (~mask_q + {{(WIDTH-1){1'b0}}, 1'b1});
    assign one_left = (mask_q != '0) && ((mask_q & ~low_oh) == '0);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        empty_d = empty_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StEmit;
                    mask_d  = data_i;
                    empty_d = (data_i == '0);
                end
            end
            StEmit: begin
                if (beat_done) begin
                    mask_d = mask_q & ~low_oh;
                    if (empty_q || one_left) begin
                        state_d = StIdle;
                        mask_d  = '0;
                        empty_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                mask_d  = '0;
                empty_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            mask_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            empty_q <= empty_d;
        end
    end

    assign data_ready_o = (state_q == StIdle);
    assign idx_val_o    = (state_q == StEmit);
    assign idx_o        = low_idx;
    assign idx_last_o   = (state_q == StEmit) && (empty_q || one_left);
    assign idx_empty_o  = (state_q == StEmit) && empty_q;

`ifdef BIT_INDEX_SERIALIZER_COUNT_EN
    logic [IdxW:0] pop_cnt;
    logic [IdxW:0] count_q;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + (IdxW + 1)'(data_i[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= pop_cnt;
        end
    end

    assign count_o = count_q;
`endif

endmodule

// File: tb/tb_bit_index_serializer.sv
// Directed scoreboard bench for bit_index_serializer at WIDTH=8.
module tb_bit_index_serializer;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       data_val_i = 1'b0;
    logic       data_ready_o;
    logic [2:0] idx_o;
    logic       idx_val_o;
    logic       idx_last_o;
    logic       idx_empty_o;
    logic       idx_ready_i = 1'b0;
`ifdef BIT_INDEX_SERIALIZER_COUNT_EN
    logic [3:0] count_o;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] idx;
        logic       last;
        logic       empty;
    } beat_t;

    beat_t      exp_q[$];
    logic [3:0] exp_count = '0;

    always #5 clk_i = ~clk_i;

    bit_index_serializer #(
        .WIDTH(8)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .data_i      (data_i),
        .data_val_i  (data_val_i),
        .data_ready_o(data_ready_o),
        .idx_o       (idx_o),
        .idx_val_o   (idx_val_o),
        .idx_last_o  (idx_last_o),
        .idx_empty_o (idx_empty_o),
`ifdef BIT_INDEX_SERIALIZER_COUNT_EN
        .count_o     (count_o),
`endif
        .idx_ready_i (idx_ready_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        beat_t b;
        exp_count = '0;
        if (w == 8'h00) begin
            b.idx = 3'd0; b.last = 1'b1; b.empty = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w[i]) begin
                    exp_count = exp_count + 4'd1;
                    b.idx   = 3'(i);
                    b.last  = ((w >> (i + 1)) == 8'h00);
                    b.empty = 1'b0;
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // Consume every expected beat; stall inserts a wait cycle after each accepted beat.
    task automatic drain(input bit stall);
        bit rdy = 1'b1;
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 64) begin
            @(negedge clk_i);
            cyc++;
            idx_ready_i = rdy;
            check("idx_val", 32'(idx_val_o), 32'd1);
            check("data_ready_busy", 32'(data_ready_o), 32'd0);
            check("idx", 32'(idx_o), 32'(exp_q[0].idx));
            check("last", 32'(idx_last_o), 32'(exp_q[0].last));
            check("empty", 32'(idx_empty_o), 32'(exp_q[0].empty));
`ifdef BIT_INDEX_SERIALIZER_COUNT_EN
            check("count", 32'(count_o), 32'(exp_count));
`endif
            if (rdy) begin
                void'(exp_q.pop_front());
            end
            rdy = stall ? ~rdy : 1'b1;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk_i);
        idx_ready_i = 1'b0;
        check("ready_after_word", 32'(data_ready_o), 32'd1);
        check("val_after_word", 32'(idx_val_o), 32'd0);
    endtask

    task automatic send_word(input logic [7:0] w, input bit stall);
        @(negedge clk_i);
        check("ready_before_word", 32'(data_ready_o), 32'd1);
        data_i     = w;
        data_val_i = 1'b1;
        push_word(w);
        @(posedge clk_i);
        #1 data_val_i = 1'b0;
        drain(stall);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_ready", 32'(data_ready_o), 32'd1);
        check("rst_val", 32'(idx_val_o), 32'd0);
        check("rst_idx", 32'(idx_o), 32'd0);
        check("rst_last", 32'(idx_last_o), 32'd0);
        check("rst_empty", 32'(idx_empty_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        send_word(8'b1010_0101, 1'b0);
        send_word(8'h00, 1'b0);
        send_word(8'hFF, 1'b1);
        send_word(8'h80, 1'b0);

        // Back-to-back valid: second word must wait for IDLE.
        @(negedge clk_i);
        data_i     = 8'h81;
        data_val_i = 1'b1;
        push_word(8'h81);
        @(posedge clk_i);
        #1 data_i = 8'h10;
        drain(1'b0);
        push_word(8'h10);
        @(posedge clk_i);
        #1 data_val_i = 1'b0;
        drain(1'b0);

        // Reset mid-word after beat 2 of 8'b0110_0100.
        @(negedge clk_i);
        data_i     = 8'b0110_0100;
        data_val_i = 1'b1;
        @(posedge clk_i);
        #1 data_val_i = 1'b0;
        @(negedge clk_i);
        idx_ready_i = 1'b1;
        check("mid_idx2", 32'(idx_o), 32'd2);
        @(negedge clk_i);
        idx_ready_i = 1'b0;
        check("mid_idx5", 32'(idx_o), 32'd5);
        #2 rst_n_i = 1'b0;
        #1;
        check("async_ready", 32'(data_ready_o), 32'd1);
        check("async_val", 32'(idx_val_o), 32'd0);
        check("async_idx", 32'(idx_o), 32'd0);
        check("async_last", 32'(idx_last_o), 32'd0);
        check("async_empty", 32'(idx_empty_o), 32'd0);
`ifdef BIT_INDEX_SERIALIZER_COUNT_EN
        check("async_count", 32'(count_o), 32'd0);
`endif
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i     = 1'b1;
        idx_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("no_beat_after_rst", 32'(idx_val_o), 32'd0);
        end
        idx_ready_i = 1'b0;

        send_word(8'b0011_1100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
